mult_div_unit: RTL and testbench

- Iterative multiply/divide unit that sits directly downstream of the register file.
- Consumes the rs/rt read-port values for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- Exposes busy, which the control/PC logic uses to stall issue while an operation runs.

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit: 32-cycle shift-add multiply, restoring divide,
// one sign-fix cycle, and the architectural HI/LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remv;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    // MULT and DIV have op[0]=0; only those use signed magnitudes
    w_sgn   = ~op[0];
    w_mag_a = (w_sgn && srcA[WIDTH-1]) ? -srcA : srcA;
    w_mag_b = (w_sgn && srcB[WIDTH-1]) ? -srcB : srcB;

    w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

    w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_ge    = r_rem[WIDTH] || (w_shift >= {1'b0, r_b});

    w_prod  = r_neg_q ? -r_acc : r_acc;
    w_quo   = r_neg_q ? -r_quo : r_quo;
    w_remv  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_state  <= S_MUL;
                r_busy   <= 1'b1;
                r_is_div <= 1'b0;
                r_cnt    <= '0;
                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                r_b      <= w_mag_a;
                r_neg_q  <= w_sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                r_neg_r  <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                r_state  <= S_DIV;
                r_busy   <= 1'b1;
                r_is_div <= 1'b1;
                r_cnt    <= '0;
                r_quo    <= w_mag_a;
                r_rem    <= '0;
                r_b      <= w_mag_b;
                r_a_raw  <= srcA;
                r_neg_q  <= w_sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                r_neg_r  <= w_sgn & srcA[WIDTH-1];
              end
              OP_MTHI: r_hi <= srcA;
              OP_MTLO: r_lo <= srcA;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          // product accumulates in the top half while the multiplier shifts out the bottom
          r_acc <= {w_madd, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_b == '0) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_remv;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned results,
// divide-by-zero, start-while-busy, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns #1 after E0 with operands scrambled.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
  endtask

  // Edges after E0 until done is seen; -1 if it never arrives.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_ctl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
    reset = 1'b0;
  endtask

  task automatic test_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int lat;
    start_op(o, a, b);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", nm, busy); end
    wait_done(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL %s_latency got %0d want 33", nm, lat); end
    checks++; if (hi !== ehi || lo !== elo) begin errors++; $display("FAIL %s_result got hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, ehi, elo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", nm, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
  endtask

  task automatic test_ignore_while_busy();
    int ndone, at;
    ndone = 0; at = -1;
    start_op(3'b001, 32'd3, 32'd5);
    srcA = 32'hDEAD_BEEF; srcB = 32'h0000_0007;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin start = 1'b1; op = 3'b010; end
      @(posedge clk); #1;
      if (k == 10) start = 1'b0;
      if (done) begin ndone++; at = k; end
    end
    checks++; if (ndone !== 1 || at !== 33) begin errors++; $display("FAIL busy_ignore_done got count=%0d edge=%0d want 1 at 33", ndone, at); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0000_000F) begin errors++; $display("FAIL busy_ignore_result got hi=%h lo=%h want 0 0000000f", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = 3'b100; srcA = 32'h1234_5678;
    @(posedge clk); #1;
    checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h busy=%b done=%b want 12345678 0 0", hi, busy, done); end
    op = 3'b101; srcA = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want 12345678 9abcdef0 0 0", hi, lo, busy, done); end
    start = 1'b1; op = 3'b110; srcA = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h want 0 12345678 9abcdef0", busy, hi, lo); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic seen;
    start = 1'b1; op = 3'b100; srcA = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    start = 1'b0;
    start_op(3'b000, 32'd3, 32'd4);
    seen = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++; if (hi !== 32'hAAAA_AAAA || busy !== 1'b1 || seen) begin errors++; $display("FAIL hold_during_busy got hi=%h busy=%b done_seen=%b want aaaaaaaa 1 0", hi, busy, seen); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done); end
    start_op(3'b001, 32'd6, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_start got busy=%b want 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL post_reset_result got lat=%0d hi=%h lo=%h want 33 0 0000002a", lat, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mul(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    test_mul(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    test_mul(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    test_mul(3'b011, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, "divu");
    test_mul(3'b011, 32'h0000_0064, 32'h0,         32'h0000_0064, 32'hFFFF_FFFF, "divu_zero");
    test_mul(3'b010, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    test_mul(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    test_ignore_while_busy();
    test_mthi_mtlo();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
